// File: rtl/minisys_io_pkg.sv
// Shared definitions for the minisys IO blocks: register offsets,
// status bit positions and the UART transmitter state encoding.
package minisys_io_pkg;

    // Register offsets within the UART block
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd2;

    // Status register bit positions
    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_FULL    = 1;
    localparam int unsigned ST_EMPTY   = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_CNT_LSB = 4;
    localparam int unsigned ST_CNT_W   = 3;

    // Transmitter FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO for the UART transmitter. Push and pop in the same
// cycle both take effect, so a full FIFO can accept a push while popping.
module uart_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array, no reset needed since occupancy gates every read
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped UART transmitter: CPU register decode, a byte FIFO, and an
// 8N1 serial FSM with a per-bit baud counter. uart_tx is driven from a flop.
module uart_tx_io #(
    parameter int unsigned CLKS_PER_BIT = 145,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uartcs,
    input  logic        uartwrite,
    input  logic        uartread,
    input  logic [1:0]  uartaddr,
    input  logic [15:0] uartwdata,
    output logic [15:0] uartrdata,
    output logic        uart_tx
);

    import minisys_io_pkg::*;

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BAUD_W = 16;

    tx_state_t         r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              r_ovf;

    logic              w_wr;
    logic              w_push;
    logic              w_ovf_clr;
    logic              w_pop;
    logic              w_baud_last;
    logic [7:0]        w_head;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [15:0]       w_status;
    logic              w_status_rd;
    logic              w_unused_wdata_hi;

    // IO accesses are ignored while reset is asserted
    assign w_wr      = uartcs & uartwrite & ~reset;
    assign w_push    = w_wr & (uartaddr == REG_TXDATA);
    assign w_ovf_clr = w_wr & (uartaddr == REG_STATUS);
    assign w_pop     = (r_state == S_IDLE) & ~w_empty & ~reset;

    assign w_baud_last       = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_unused_wdata_hi = &{1'b0, uartwdata[15:8]};
    assign uart_tx           = r_tx;

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (uartwdata[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Sticky overflow: a dropped push wins over a same-cycle clear
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_push & w_full & ~w_pop) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Serial framing FSM: start bit, 8 data bits LSB first, stop bit
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift   <= w_head;
                        r_state   <= S_START;
                        r_tx      <= 1'b0;
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                    end
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                        r_baud  <= '0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state   <= S_STOP;
                            r_tx      <= 1'b1;
                            r_bit_idx <= '0;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_baud_last) begin
                        r_state <= S_IDLE;
                        r_baud  <= '0;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // Status word assembly and read mux, zero unless the status register is read
    always_comb begin
        w_status                          = '0;
        w_status[ST_BUSY]                 = (r_state != S_IDLE);
        w_status[ST_FULL]                 = w_full;
        w_status[ST_EMPTY]                = w_empty;
        w_status[ST_OVF]                  = r_ovf;
        w_status[ST_CNT_LSB +: ST_CNT_W]  = ST_CNT_W'(w_count);
        w_status_rd                       = uartcs & uartread & (uartaddr == REG_STATUS);
        uartrdata                         = w_status_rd ? w_status : '0;
    end

endmodule

// File: tb/tb_uart_tx_io.sv
// Directed and randomized bench for uart_tx_io with CLKS_PER_BIT=4.
// A line receiver decodes every frame and compares it with the queue of bytes
// the bench expects to be accepted; status words are derived from FIFO
// occupancy rules.
module tb_uart_tx_io;

    localparam int unsigned CPB   = 4;
    localparam int unsigned FRAME = 10 * CPB + 1;

    logic        clock = 1'b0;
    logic        reset;
    logic        uartcs;
    logic        uartwrite;
    logic        uartread;
    logic [1:0]  uartaddr;
    logic [15:0] uartwdata;
    logic [15:0] uartrdata;
    logic        uart_tx;

    uart_tx_io #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .uartcs    (uartcs),
        .uartwrite (uartwrite),
        .uartread  (uartread),
        .uartaddr  (uartaddr),
        .uartwdata (uartwdata),
        .uartrdata (uartrdata),
        .uart_tx   (uart_tx)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clock) cyc++;

    logic [7:0] exp_q[$];
    int         start_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Line receiver: samples mid-bit, drops any frame cut short by reset
    logic       m_active = 1'b0;
    logic       m_prev   = 1'b1;
    int         m_cnt    = 0;
    int         m_k      = 0;
    logic [7:0] m_byte   = '0;
    logic [7:0] m_exp    = '0;

    always @(negedge clock) begin
        if (reset) begin
            m_active = 1'b0;
            m_prev   = 1'b1;
        end else begin
            if (!m_active) begin
                if (m_prev && !uart_tx) begin
                    m_active = 1'b1;
                    m_cnt    = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                m_cnt++;
            end
            if (m_active && m_cnt >= 2 && ((m_cnt - 2) % CPB) == 0) begin
                m_k = (m_cnt - 2) / CPB;
                if (m_k == 0) begin
                    check("rx_start_bit", 32'(uart_tx), 32'd0);
                end else if (m_k <= 8) begin
                    m_byte[m_k-1] = uart_tx;
                end else begin
                    check("rx_stop_bit", 32'(uart_tx), 32'd1);
                    check("rx_byte_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        m_exp = exp_q.pop_front();
                        check("rx_byte", 32'(m_byte), 32'(m_exp));
                    end
                    m_active = 1'b0;
                end
            end
            m_prev = uart_tx;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        uartcs    = 1'b1;
        uartwrite = 1'b1;
        uartread  = 1'b0;
        uartaddr  = a;
        uartwdata = d;
        tick();
        uartwrite = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic cs, output logic [15:0] v);
        uartwrite = 1'b0;
        uartcs    = cs;
        uartread  = 1'b1;
        uartaddr  = a;
        #1;
        v = uartrdata;
    endtask

    task automatic drain(input string tag);
        logic [15:0] v;
        logic        done;
        done = 1'b0;
        v    = '0;
        for (int i = 0; i < 6 * int'(FRAME) + 20; i++) begin
            tick();
            rd(2'd2, 1'b1, v);
            if (v == 16'h0004 && !m_active) begin
                done = 1'b1;
                break;
            end
        end
        check({tag, "_drain_done"}, 32'(done), 32'd1);
        check({tag, "_all_bytes_seen"}, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return b[k-1];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [15:0] v;
    logic [15:0] es;
    logic [1:0]  ra;
    logic [15:0] rdat;
    int          acc;
    int          cnt;
    logic        ovf;
    logic        all_high;

    initial begin
        reset     = 1'b1;
        uartcs    = 1'b0;
        uartwrite = 1'b0;
        uartread  = 1'b0;
        uartaddr  = '0;
        uartwdata = '0;
        repeat (3) tick();
        check("reset_tx", 32'(uart_tx), 32'd1);
        reset = 1'b0;
        rd(2'd2, 1'b1, v);
        check("reset_status", 32'(v), 32'h0004);

        // Non-status reads return zero
        rd(2'd0, 1'b1, v); check("rd_off0", 32'(v), 32'h0);
        rd(2'd1, 1'b1, v); check("rd_off1", 32'(v), 32'h0);
        rd(2'd3, 1'b1, v); check("rd_off3", 32'(v), 32'h0);
        rd(2'd2, 1'b0, v); check("rd_off2_nocs", 32'(v), 32'h0);

        // Single frame, cycle-exact waveform and busy flag
        start_q.delete();
        wr(2'd0, 16'hAB55);
        exp_q.push_back(8'h55);
        rd(2'd2, 1'b1, v);
        check("t1_queued_status", 32'(v), 32'h0010);
        check("t1_idle_tx", 32'(uart_tx), 32'd1);
        for (int j = 1; j <= int'(FRAME); j++) begin
            tick();
            rd(2'd2, 1'b1, v);
            if (j < int'(FRAME)) begin
                check("t1_line", 32'(uart_tx), 32'(frame_bit(8'h55, (j - 1) / int'(CPB))));
                check("t1_busy", 32'(v[0]), 32'd1);
            end else begin
                check("t1_line_after", 32'(uart_tx), 32'd1);
                check("t1_status_after", 32'(v), 32'h0004);
            end
        end
        drain("t1");

        // Five back-to-back writes while idle: all accepted, 41-cycle spacing
        start_q.delete();
        for (int i = 1; i <= 5; i++) begin
            wr(2'd0, 16'(i));
            exp_q.push_back(8'(i));
        end
        rd(2'd2, 1'b1, v);
        check("t2_status_full", 32'(v), 32'h0043);
        drain("t2");
        check("t2_frames", 32'(start_q.size()), 32'd5);
        for (int i = 1; i < start_q.size(); i++) begin
            check("t2_spacing", 32'(start_q[i] - start_q[i-1]), 32'(FRAME));
        end

        // Overflow while transmitting, then clear
        for (int i = 0; i < 5; i++) begin
            wr(2'd0, 16'(8'h10 + i));
            exp_q.push_back(8'(8'h10 + i));
        end
        wr(2'd0, 16'h00AA);
        rd(2'd2, 1'b1, v);
        check("t3_overflow_status", 32'(v), 32'h004B);
        wr(2'd2, 16'hFFFF);
        rd(2'd2, 1'b1, v);
        check("t3_overflow_cleared", 32'(v), 32'h0043);
        drain("t3");

        // Push into a full FIFO on the exact cycle the FSM pops
        for (int i = 0; i < 5; i++) begin
            wr(2'd0, 16'(8'h20 + i));
            exp_q.push_back(8'(8'h20 + i));
        end
        repeat (int'(FRAME) - 4) tick();
        rd(2'd2, 1'b1, v);
        check("t4_full_idle_status", 32'(v), 32'h0042);
        wr(2'd0, 16'h0025);
        exp_q.push_back(8'h25);
        rd(2'd2, 1'b1, v);
        check("t4_accept_on_pop", 32'(v), 32'h0043);
        drain("t4");

        // Randomized bursts within one frame time of idle
        for (int r = 0; r < 8; r++) begin
            acc = 0;
            ovf = 1'b0;
            for (int c = 0; c < 30; c++) begin
                if ($urandom_range(3) == 0) begin
                    ra   = 2'($urandom_range(3));
                    rdat = 16'($urandom);
                    if (ra == 2'd0) begin
                        if (acc < 5) begin
                            acc++;
                            exp_q.push_back(rdat[7:0]);
                        end else begin
                            ovf = 1'b1;
                        end
                    end else if (ra == 2'd2) begin
                        ovf = 1'b0;
                    end
                    wr(ra, rdat);
                end else begin
                    tick();
                end
            end
            tick();
            cnt    = (acc == 0) ? 0 : acc - 1;
            es     = '0;
            es[0]  = (acc > 0);
            es[1]  = (acc == 5);
            es[2]  = (acc <= 1);
            es[3]  = ovf;
            es[6:4] = 3'(cnt);
            rd(2'd2, 1'b1, v);
            check("rand_status", 32'(v), 32'(es));
            wr(2'd2, 16'h0000);
            drain("rand");
        end

        // Reset in the middle of data bit 3 abandons everything
        wr(2'd0, 16'h0077);
        wr(2'd0, 16'h0078);
        repeat (17) tick();
        reset = 1'b1;
        wr(2'd0, 16'h0099);
        check("t6_tx_after_reset", 32'(uart_tx), 32'd1);
        reset = 1'b0;
        start_q.delete();
        rd(2'd2, 1'b1, v);
        check("t6_status_after_reset", 32'(v), 32'h0004);
        all_high = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (uart_tx !== 1'b1) all_high = 1'b0;
        end
        check("t6_line_stays_idle", 32'(all_high), 32'd1);
        check("t6_no_frames", 32'(start_q.size()), 32'd0);
        rd(2'd2, 1'b1, v);
        check("t6_status_final", 32'(v), 32'h0004);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
